// File: rtl/fit_eval_pkg.sv
// Shared types and default widths for the knapsack fitness evaluation stage.
package fit_eval_pkg;

  localparam int unsigned GENE_NUM_DEF = 16;
  localparam int unsigned IDX_W_DEF    = 4;
  localparam int unsigned VAL_W_DEF    = 8;
  localparam int unsigned WGT_W_DEF    = 8;
  localparam int unsigned SUM_W_DEF    = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/knapsack_fitness_eval_if.sv
// Request, item-table and result signals of the fitness evaluation stage.
interface knapsack_fitness_eval_if
  import fit_eval_pkg::*;
#(
  parameter int unsigned GENE_NUM = GENE_NUM_DEF,
  parameter int unsigned IDX_W    = IDX_W_DEF,
  parameter int unsigned VAL_W    = VAL_W_DEF,
  parameter int unsigned WGT_W    = WGT_W_DEF,
  parameter int unsigned SUM_W    = SUM_W_DEF
);

  logic                start_i;
  logic                ready_o;
  logic [GENE_NUM-1:0] chrom_i;
  logic [SUM_W-1:0]    cap_i;
  logic                item_rd_o;
  logic [IDX_W-1:0]    item_addr_o;
  logic [VAL_W-1:0]    item_val_i;
  logic [WGT_W-1:0]    item_wgt_i;
  logic [SUM_W-1:0]    fitness_o;
  logic                overweight_o;
  logic [SUM_W-1:0]    weight_o;
  logic                fitness_vld_o;
  logic                fitness_rdy_i;

  modport master (
    output start_i, chrom_i, cap_i, item_val_i, item_wgt_i, fitness_rdy_i,
    input  ready_o, item_rd_o, item_addr_o, fitness_o, overweight_o, weight_o,
           fitness_vld_o
  );

  modport slave (
    input  start_i, chrom_i, cap_i, item_val_i, item_wgt_i, fitness_rdy_i,
    output ready_o, item_rd_o, item_addr_o, fitness_o, overweight_o, weight_o,
           fitness_vld_o
  );

endinterface

// File: rtl/knapsack_fitness_eval_cnt.sv
// Team up-counter with synchronous clear (priority) and enable; active-low async reset.
module knapsack_fitness_eval_cnt #(
  parameter int unsigned CNT_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 clr_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (en_i) begin
      cnt_o <= cnt_o + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/knapsack_fitness_eval.sv
// Knapsack fitness evaluation: walks the item table for one chromosome, sums
// value/weight of selected items and zeroes fitness when over capacity.
module knapsack_fitness_eval
  import fit_eval_pkg::*;
#(
  parameter int unsigned GENE_NUM = GENE_NUM_DEF,
  parameter int unsigned IDX_W    = IDX_W_DEF,
  parameter int unsigned VAL_W    = VAL_W_DEF,
  parameter int unsigned WGT_W    = WGT_W_DEF,
  parameter int unsigned SUM_W    = SUM_W_DEF
) (
  input logic                    clk_i,
  input logic                    rst_i,
  knapsack_fitness_eval_if.slave fit_bus
);

  state_t              state;
  state_t              state_nxt;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_d1;
  logic                rd_d1;
  logic [GENE_NUM-1:0] chrom_q;
  logic [SUM_W-1:0]    cap_q;
  logic [SUM_W-1:0]    val_acc;
  logic [SUM_W-1:0]    wgt_acc;
  logic [SUM_W-1:0]    fitness;
  logic [SUM_W-1:0]    weight;
  logic                overweight;
  logic                fitness_vld;
  logic                over_cap;
  logic                cnt_en;
  logic                cnt_clr;
  logic                rd;
  logic                accept;
  logic                load_res;
  logic                retire;

  knapsack_fitness_eval_cnt #(
    .CNT_WIDTH (IDX_W)
  ) u_gene_cnt (
    .clk_i  (clk_i),
    .rst_ni (~rst_i),
    .en_i   (cnt_en),
    .clr_i  (cnt_clr),
    .cnt_o  (idx)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // DONE spends its first cycle latching the result, since the last item only
  // lands in the accumulators on the edge that enters DONE.
  always_comb begin
    state_nxt = state;
    cnt_en    = 1'b0;
    cnt_clr   = 1'b0;
    rd        = 1'b0;
    accept    = 1'b0;
    load_res  = 1'b0;
    retire    = 1'b0;
    unique case (state)
      IDLE: begin
        if (fit_bus.start_i) begin
          accept    = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        rd     = 1'b1;
        cnt_en = 1'b1;
        if (idx == IDX_W'(GENE_NUM - 1)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        state_nxt = DONE;
      end
      DONE: begin
        if (!fitness_vld) begin
          load_res = 1'b1;
        end else if (fit_bus.fitness_rdy_i) begin
          retire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign over_cap = (wgt_acc > cap_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_d1       <= 1'b0;
      idx_d1      <= '0;
      chrom_q     <= '0;
      cap_q       <= '0;
      val_acc     <= '0;
      wgt_acc     <= '0;
      fitness     <= '0;
      weight      <= '0;
      overweight  <= 1'b0;
      fitness_vld <= 1'b0;
    end else begin
      rd_d1  <= rd;
      idx_d1 <= idx;
      if (accept) begin
        chrom_q <= fit_bus.chrom_i;
        cap_q   <= fit_bus.cap_i;
        val_acc <= '0;
        wgt_acc <= '0;
      end else if (rd_d1 && chrom_q[idx_d1]) begin
        val_acc <= val_acc + SUM_W'(fit_bus.item_val_i);
        wgt_acc <= wgt_acc + SUM_W'(fit_bus.item_wgt_i);
      end
      if (load_res) begin
        weight      <= wgt_acc;
        overweight  <= over_cap;
        fitness     <= over_cap ? '0 : val_acc;
        fitness_vld <= 1'b1;
      end else if (retire) begin
        fitness_vld <= 1'b0;
      end
    end
  end

  assign fit_bus.ready_o       = (state == IDLE);
  assign fit_bus.item_rd_o     = rd;
  assign fit_bus.item_addr_o   = idx;
  assign fit_bus.fitness_o     = fitness;
  assign fit_bus.weight_o      = weight;
  assign fit_bus.overweight_o  = overweight;
  assign fit_bus.fitness_vld_o = fitness_vld;

endmodule
